// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and vblank arbiter state encoding.
package vga_pkg;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;
endpackage

// File: rtl/vblank_update_arbiter_if.sv
// vblank_update_arbiter_if: request/grant bundle between display-state writers and the arbiter.
interface vblank_update_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [2:0]       gnt_id;
    logic             busy;
    logic             win_open;
    logic             timeout_err;
    modport master (output req, done, input gnt, gnt_id, busy, win_open, timeout_err);
    modport slave  (input req, done, output gnt, gnt_id, busy, win_open, timeout_err);
endinterface

// File: rtl/vblank_update_arbiter_rr_picker.sv
// rr_picker: combinational pick of the first request at or above ptr, wrapping.
// With VBLANK_ARB_PRIORITY_EN, req[0] always wins and is excluded from the rotation.
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] pick,
    output logic [2:0]       idx
);
    logic [N_REQ-1:0] cand;
`ifdef VBLANK_ARB_PRIORITY_EN
    assign cand = req & ~N_REQ'(1);
`else
    assign cand = req;
`endif
    // Walk offsets from far to near so the closest requester to ptr is written last.
    always_comb begin
        pick = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (cand[j] && j == (int'(ptr) + i) % N_REQ) begin
                    pick = '0;
                    pick[j] = 1'b1;
                    idx = 3'(j);
                end
            end
        end
`ifdef VBLANK_ARB_PRIORITY_EN
        if (req[0]) begin
            pick = N_REQ'(1);
            idx = '0;
        end
`endif
    end
endmodule

// File: rtl/vblank_update_arbiter.sv
// vblank_update_arbiter: round-robin display-state write arbiter; grants start only in vblank.
// VBLANK_ARB_PRIORITY_EN makes requester 0 fixed-priority while the rest rotate.
module vblank_update_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int V_WIN_FIRST = V_ACTIVE,
    parameter int V_WIN_LAST  = V_TOTAL - 5,
    parameter int MAX_GRANT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    vblank_update_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_GRANT);
    logic [1:0]       state;
    logic [2:0]       ptr, next_ptr, pick_id;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] pick;
    logic             release_g, timeout, unused_hcount;
    assign unused_hcount = ^hcount;
    rr_picker #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .pick(pick), .idx(pick_id));
    assign release_g = |(bus.done & bus.gnt) || ~|(bus.req & bus.gnt);
    assign timeout = cnt == CW'(MAX_GRANT - 1);
    assign bus.busy = state == GRANT;
`ifdef VBLANK_ARB_PRIORITY_EN
    assign next_ptr = bus.gnt_id == 3'd0 ? ptr : bus.gnt_id == 3'(N_REQ - 1) ? 3'd1 : bus.gnt_id + 3'd1;
`else
    assign next_ptr = bus.gnt_id == 3'(N_REQ - 1) ? 3'd0 : bus.gnt_id + 3'd1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            bus.gnt <= '0;
            bus.gnt_id <= '0;
            bus.win_open <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.win_open <= vcount >= 10'(V_WIN_FIRST) && vcount <= 10'(V_WIN_LAST);
            bus.timeout_err <= 1'b0;
            if (state == IDLE && bus.win_open && |bus.req) begin
                state <= GRANT;
                bus.gnt <= pick;
                bus.gnt_id <= pick_id;
                cnt <= '0;
            end else if (state == GRANT) begin
                cnt <= &cnt ? cnt : cnt + 1'b1;
                if (release_g || timeout) begin
                    state <= HOLDOFF;
                    bus.gnt <= '0;
                    bus.timeout_err <= timeout && !release_g;
                end
            end else if (state == HOLDOFF) begin
                state <= IDLE;
                ptr <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_vblank_update_arbiter.sv
// tb_vblank_update_arbiter: directed self-checking bench for vblank_update_arbiter.
module tb_vblank_update_arbiter;
    import vga_pkg::*;
`ifdef VBLANK_ARB_PRIORITY_EN
    localparam int TO_NEXT = 1;
`else
    localparam int TO_NEXT = 2;
`endif
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcount, vcount;
    int         checks = 0, errors = 0;

    vblank_update_arbiter_if #(.N_REQ(4)) bus ();
    vblank_update_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        hcount = (hcount == 10'(H_TOTAL - 1)) ? 10'd0 : hcount + 10'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_done(input logic [3:0] v);
        bus.done = v;
        tick();
        bus.done = '0;
    endtask

    task automatic wait_gnt(input string tag, input int exp);
        for (int n = 0; n < 8 && bus.gnt == '0; n++) tick();
        chk(tag, int'(bus.gnt), exp);
    endtask

    task automatic run_order(input string tag, input logic [3:0] seq [6], input int n);
        int id;
        for (int k = 0; k < n; k++) begin
            if (k == 0) wait_gnt(tag, int'(seq[k]));
            else begin
                tick();
                chk(tag, int'(bus.gnt), int'(seq[k]));
            end
            id = 0;
            for (int j = 0; j < 4; j++) if (seq[k][j]) id = j;
            chk({tag, "_id"}, int'(bus.gnt_id), id);
            if (k < n - 1) begin
                tick();
                tick();
                pulse_done(seq[k]);
                chk({tag, "_gap0"}, int'(bus.gnt), 0);
                tick();
                chk({tag, "_gap1"}, int'(bus.gnt), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] ord [6];
        rst_n = 1'b0;
        hcount = 10'(H_ACTIVE);
        vcount = 10'd100;
        bus.req = '0;
        bus.done = '0;
        tick();
        tick();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_gnt_id", int'(bus.gnt_id), 0);
        chk("rst_win", int'(bus.win_open), 0);
        chk("rst_to", int'(bus.timeout_err), 0);
        rst_n = 1'b1;

        // grant waits for the window, then follows win_open by one cycle
        bus.req = 4'b0001;
        repeat (3) begin
            tick();
            chk("closed_gnt", int'(bus.gnt), 0);
        end
        chk("closed_win", int'(bus.win_open), 0);
        vcount = 10'd480;
        tick();
        chk("win_rise", int'(bus.win_open), 1);
        chk("win_rise_gnt", int'(bus.gnt), 0);
        tick();
        chk("first_gnt", int'(bus.gnt), 1);
        chk("first_busy", int'(bus.busy), 1);
        bus.req = '0;
        pulse_done(4'b0001);
        chk("first_rel", int'(bus.gnt), 0);
        chk("first_rel_busy", int'(bus.busy), 0);

        // rotation with done three cycles into each grant
        do_reset();
        bus.req = 4'b1111;
`ifdef VBLANK_ARB_PRIORITY_EN
        ord = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b0000};
`else
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
`endif
        run_order("rr", ord, 5);

        // last grant never finishes: forced revoke; window closing mid-grant is not a revoke
        for (int i = 1; i <= 4095; i++) begin
            tick();
            if (i == 10) vcount = 10'd100;
        end
        chk("hold_gnt", int'(bus.gnt), 1);
        chk("hold_busy", int'(bus.busy), 1);
        chk("hold_win", int'(bus.win_open), 0);
        chk("hold_to", int'(bus.timeout_err), 0);
        tick();
        chk("to_gnt", int'(bus.gnt), 0);
        chk("to_err", int'(bus.timeout_err), 1);
        tick();
        chk("to_pulse", int'(bus.timeout_err), 0);
        repeat (3) begin
            tick();
            chk("closed_pending", int'(bus.gnt), 0);
        end
        vcount = 10'd480;
        wait_gnt("to_next", TO_NEXT);
        bus.req = '0;
        repeat (3) tick();

        // request raised after the window: served in the next frame only
        vcount = 10'd521;
        tick();
        bus.req = 4'b0010;
        repeat (3) tick();
        chk("late_win", int'(bus.win_open), 0);
        chk("late_gnt", int'(bus.gnt), 0);
        vcount = 10'd524;
        tick();
        vcount = 10'd0;
        tick();
        vcount = 10'd479;
        tick();
        chk("wrap_gnt", int'(bus.gnt), 0);
        vcount = 10'd480;
        tick();
        chk("frame_gnt0", int'(bus.gnt), 0);
        tick();
        chk("frame_gnt", int'(bus.gnt), 2);
        chk("frame_id", int'(bus.gnt_id), 1);
        pulse_done(4'b0001);
        chk("stray_done", int'(bus.gnt), 2);

        // asynchronous reset mid-grant
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_gnt", int'(bus.gnt), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_id", int'(bus.gnt_id), 0);
        chk("async_win", int'(bus.win_open), 0);
        rst_n = 1'b1;
        vcount = 10'd520;
        bus.req = 4'b1111;
        wait_gnt("rst_ptr", 1);
        bus.req = 4'b1110;
        tick();
        chk("abandon", int'(bus.gnt), 0);
        tick();
        chk("abandon_idle", int'(bus.gnt), 0);
        tick();
        chk("abandon_next", int'(bus.gnt), 2);
        vcount = 10'd521;
        tick();
        chk("no_revoke", int'(bus.gnt), 2);
        chk("edge_win", int'(bus.win_open), 0);
        bus.req = 4'b1100;
        pulse_done(4'b0010);
        chk("edge_rel", int'(bus.gnt), 0);
        repeat (3) tick();
        chk("closed_idle", int'(bus.gnt), 0);
        chk("closed_busy", int'(bus.busy), 0);

`ifdef VBLANK_ARB_PRIORITY_EN
        do_reset();
        vcount = 10'd480;
        bus.req = 4'b0111;
        ord = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b0010};
        run_order("prio", ord, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
